// File: rtl/rect_key_ctrl.sv
// rect_key_ctrl: RECTANGLE-style 128-bit key schedule controller, 26 round keys per operation.
// Define RECT_KEY_ZEROIZE_EN to clear the key register when an operation completes.
module rect_key_ctrl (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] iv_key,
    output logic         o_select,
    output logic [63:0]  ov_roundkey,
    output logic [4:0]   ov_round,
    output logic         o_busy,
    output logic         o_last,
    output logic         o_done
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [63:0] SBOX = 64'h24F8D30B97E1AC56;
    state_t state;
    logic [3:0][31:0] key, sb, nxt;
    logic [4:0] idx, rc;
    logic [3:0] col, nib;
    always_comb begin
        sb = key;
        col = '0;
        nib = '0;
        for (int j = 0; j < 8; j++) begin
            col = {key[3][j], key[2][j], key[1][j], key[0][j]};
            nib = SBOX[4*col +: 4];
            sb[0][j] = nib[0];
            sb[1][j] = nib[1];
            sb[2][j] = nib[2];
            sb[3][j] = nib[3];
        end
        nxt[0] = {sb[0][23:0], sb[0][31:24]} ^ sb[1] ^ {27'd0, rc};
        nxt[1] = sb[2];
        nxt[2] = sb[3];
        nxt[3] = {sb[2][15:0], sb[2][31:16]} ^ sb[0];
    end
    assign o_select    = state == RUN;
    assign o_busy      = state == RUN;
    assign o_last      = state == RUN && idx == 5'd25;
    assign o_done      = o_last;
    assign ov_round    = idx;
    assign ov_roundkey = {key[3][15:0], key[2][15:0], key[1][15:0], key[0][15:0]};
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            idx   <= '0;
            rc    <= 5'h01;
            key   <= '0;
        end else if (state == IDLE) begin
            if (i_start) begin
                key   <= iv_key;
                idx   <= '0;
                rc    <= 5'h01;
                state <= RUN;
            end
        end else if (idx == 5'd25) begin
            state <= IDLE;
            idx   <= '0;
`ifdef RECT_KEY_ZEROIZE_EN
            key   <= '0;
`else
            key   <= key;
`endif
        end else begin
            idx <= idx + 5'd1;
            key <= nxt;
            rc  <= {rc[3:0], rc[4] ^ rc[2]};
        end
    end
endmodule

// File: tb/tb_rect_key_ctrl.sv
// tb_rect_key_ctrl: directed self-checking bench for rect_key_ctrl.
module tb_rect_key_ctrl;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [127:0] key = '0;
    logic sel, busy, last, done;
    logic [63:0] rkey;
    logic [4:0] rnd;
    int checks = 0, fails = 0;
    int sbox [16] = '{6, 5, 12, 10, 1, 14, 7, 9, 11, 0, 3, 13, 8, 15, 4, 2};

    always #5 clk = ~clk;

    rect_key_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .iv_key(key),
        .o_select(sel), .ov_roundkey(rkey), .ov_round(rnd),
        .o_busy(busy), .o_last(last), .o_done(done)
    );

    function automatic logic [127:0] model_step(input logic [127:0] k, input logic [4:0] rc);
        logic [31:0] r0, r1, r2, r3;
        logic [3:0] n;
        r0 = k[31:0]; r1 = k[63:32]; r2 = k[95:64]; r3 = k[127:96];
        for (int j = 0; j < 8; j++) begin
            n = 4'(sbox[{r3[j], r2[j], r1[j], r0[j]}]);
            r0[j] = n[0]; r1[j] = n[1]; r2[j] = n[2]; r3[j] = n[3];
        end
        return {{r2[15:0], r2[31:16]} ^ r0, r3, r2, {r0[23:0], r0[31:24]} ^ r1 ^ {27'd0, rc}};
    endfunction

    function automatic logic [63:0] rk(input logic [127:0] k);
        return {k[111:96], k[79:64], k[47:32], k[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({sel, rkey, rnd, busy, last, done} !== 73'd0)
            $display("FAIL %s: sel=%b rkey=%h rnd=%0d busy=%b last=%b done=%b, required all zero",
                     name, sel, rkey, rnd, busy, last, done);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle("reset_idle");
            if ({sel, rkey, rnd, busy, last, done} !== 73'd0) fails++;
        end
    endtask

    task automatic test_zero_key(input string name);
        int n = 0;
        key = '0; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({rkey, rnd, busy} !== {64'h0, 5'd0, 1'b1}) begin
            fails++;
            $display("FAIL %s_c0: rkey=%h rnd=%0d busy=%b, required 0 0 1", name, rkey, rnd, busy);
        end
        tick();
        checks++;
        if ({rkey, rnd} !== {64'h0000_0000_00FF_00FE, 5'd1}) begin
            fails++;
            $display("FAIL %s_c1: rkey=%h rnd=%0d, required 00000000_00ff00fe 1", name, rkey, rnd);
        end
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 25) begin
            fails++;
            $display("FAIL %s_len: remaining busy cycles %0d, required 25", name, n);
        end
    endtask

    task automatic run_and_check(input logic [127:0] k, input bit hold, input string name);
        logic [127:0] m = k, k25 = '0;
        logic [4:0] rc = 5'h01;
        logic [63:0] post;
        int n = 0;
        key = k; start = 1'b1;
        checks++;
        if (sel !== 1'b0) begin
            fails++;
            $display("FAIL %s_start_sel: sel=%b, required 0", name, sel);
        end
        tick();
        if (!hold) start = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            checks++;
            if ({rnd, rkey, last, done, sel} !== {5'(n), rk(m), n == 25, n == 25, 1'b1}) begin
                fails++;
                $display("FAIL %s_cycle%0d: rnd=%0d rkey=%h last=%b done=%b sel=%b, required %0d %h %b %b 1",
                         name, n, rnd, rkey, last, done, sel, n, rk(m), n == 25, n == 25);
            end
            if (n == 25) k25 = m;
            m = model_step(m, rc);
            rc = {rc[3:0], rc[4] ^ rc[2]};
            n++;
            tick();
        end
        checks++;
        if (n !== 26) begin
            fails++;
            $display("FAIL %s_busy_len: %0d cycles, required 26", name, n);
        end
`ifdef RECT_KEY_ZEROIZE_EN
        post = 64'h0;
`else
        post = rk(k25);
`endif
        checks++;
        if ({rkey, rnd, busy, last, done, sel} !== {post, 5'd0, 4'd0}) begin
            fails++;
            $display("FAIL %s_post: rkey=%h rnd=%0d busy=%b last=%b done=%b sel=%b, required %h 0 0 0 0 0",
                     name, rkey, rnd, busy, last, done, sel, post);
        end
        if (hold) begin
            tick();
            start = 1'b0;
            checks++;
            if ({busy, rnd, rkey} !== {1'b1, 5'd0, rk(k)}) begin
                fails++;
                $display("FAIL %s_restart: busy=%b rnd=%0d rkey=%h, required 1 0 %h", name, busy, rnd, rkey, rk(k));
            end
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        key = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE; start = 1'b1;
        tick();
        start = 1'b0;
        while (rnd !== 5'd10 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (rnd !== 5'd10) begin
            fails++;
            $display("FAIL mid_reach10: rnd=%0d, required 10", rnd);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check_idle("mid_reset");
        if ({sel, rkey, rnd, busy, last, done} !== 73'd0) fails++;
        tick();
        test_zero_key("mid_fresh");
    endtask

    initial begin
        test_reset();
        test_zero_key("zero_key");
        tick();
        run_and_check('0, 1'b0, "run_zero");
        run_and_check({128{1'b1}}, 1'b0, "run_ones");
        run_and_check(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, "run_pattern");
        run_and_check(128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1234_8765, 1'b1, "start_held");
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/rect_key_ctrl.md
RECT_KEY_CTRL -- requirements
Module: rect_key_ctrl

Interface
REQ-001 SHALL have ports i_clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have i_rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have i_start, input, 1, encryption start request, sampled only in IDLE.
REQ-004 SHALL have iv_key, input, 128, master key; row r = iv_key[32r+31:32r], r=0..3.
REQ-005 SHALL have o_select, output, 1, state-register select: 0 = load plaintext, 1 = load round output.
REQ-006 SHALL have ov_roundkey, output, 64, current round key {row3[15:0],row2[15:0],row1[15:0],row0[15:0]}, same 16-bit lane packing as the state register.
REQ-007 SHALL have ov_round, output, 5, current round index 0..25.
REQ-008 SHALL have o_busy, output, 1, high while in RUN.
REQ-009 SHALL have o_last, output, 1, high while round index = 25 (final whitening key valid).
REQ-010 SHALL have o_done, output, 1, single-cycle pulse, coincident with o_last.

Function
REQ-011 SHALL implement FSM with states IDLE and RUN.
REQ-012 IDLE + i_start=1: next edge loads key rows from iv_key, index <= 0, RC <= 5'h01, state <= RUN.
REQ-013 o_select SHALL be combinational: 0 in IDLE, 1 in RUN, so the state register captures plaintext on the start edge.
REQ-014 In RUN, each edge SHALL increment index and update the key register once; 26 RUN cycles total (index 0..25).
REQ-015 Key update, step 1: apply RECTANGLE S-box {6,5,C,A,1,E,7,9,B,0,3,D,8,F,4,2} to columns 0..7; column j nibble = {row3[j],row2[j],row1[j],row0[j]}.
REQ-016 Key update, step 2: row0' = (row0<<<8)^row1; row1' = row2; row2' = row3; row3' = (row2<<<16)^row0.
REQ-017 Key update, step 3: row0'[4:0] ^= RC; then RC <= {RC[3:0], RC[4]^RC[2]}.
REQ-018 ov_roundkey SHALL be a combinational function of the key register; K0 = low 16 bits of the master-key rows.
REQ-019 At index 25: o_last=1 and o_done=1; next edge returns to IDLE; key register holds K25 unless REQ-025 applies.
REQ-020 i_start in RUN SHALL be ignored; no restart.
REQ-021 i_start asserted on the same edge as the return to IDLE SHALL NOT start a new operation; a new start is sampled the cycle after.
REQ-022 In IDLE, ov_round=0, o_busy=0, o_last=0, o_done=0.

Reset
REQ-023 i_rst=1 on an edge SHALL force IDLE, index 0, RC 5'h01, key register 0; takes priority over i_start and RUN, including mid-operation.
REQ-024 After reset all outputs SHALL be 0 (o_select=0, ov_roundkey=64'h0).

Configuration
REQ-025 With RECT_KEY_ZEROIZE_EN defined, the key register SHALL clear to 0 on the edge leaving RUN, and ov_roundkey=0 in IDLE; without it, the key register SHALL retain K25 in IDLE.

Verification
REQ-026 Reset, then idle 5 cycles -> all outputs 0, o_select=0.
REQ-027 Key 128'h0, pulse i_start -> RUN cycle 0: ov_roundkey=64'h0, ov_round=0; cycle 1: ov_roundkey=64'h0000_0000_00FF_00FE.
REQ-028 Any key, start -> o_busy high exactly 26 cycles; o_last/o_done high only at ov_round=25; o_select=0 on the start cycle, 1 thereafter.
REQ-029 i_start held high throughout RUN -> no restart; ov_round counts 0..25 once; next start accepted only the cycle after IDLE entry.
REQ-030 i_rst asserted at ov_round=10 -> next cycle IDLE, all outputs 0; a fresh start then reproduces the REQ-027 sequence.
REQ-031 Run both builds -> post-done ov_roundkey=0 with RECT_KEY_ZEROIZE_EN; equal to K25 without it.
